// File: rtl/pcie_cpl_gen.sv
// Single-DW completion generator: one memory read per request, answered with a CplD TLP.
// Optional macro CPL_ADDR_CHECK_EN answers requests at or above ADDR_LIMIT with an Unsupported Request completion.
module pcie_cpl_gen #(
    parameter logic [15:0] COMPLETER_ID = 16'h0100,
    parameter int unsigned RD_LATENCY   = 1,
    parameter logic [15:0] ADDR_LIMIT   = 16'h1000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         is_read_request,
    output logic         pcie_read_ready,
    input  logic [15:0]  read_addr,
    input  logic [3:0]   bit_enable,
    input  logic [15:0]  RequesterID,
    input  logic [7:0]   tag,
    output logic         mem_rd_en,
    output logic [15:0]  mem_rd_addr,
    input  logic [31:0]  mem_rd_data,
    output logic [255:0] tx_data,
    output logic         tx_valid,
    output logic         tx_sop,
    output logic         tx_eop,
    input  logic         tx_ready,
    output logic [15:0]  cpl_count
);

    typedef enum logic [1:0] {IDLE, MEM_RD, WAIT, SEND} state_t;

    state_t       state;
    state_t       state_next;
    logic [15:0]  req_addr;
    logic [3:0]   req_be;
    logic [15:0]  req_id;
    logic [7:0]   req_tag;
    logic         req_ur;
    logic [3:0]   lat_cnt;
    logic [31:0]  rd_word;
    logic         accept;
    logic         handshake;
    logic         out_of_range;
    logic [11:0]  byte_count;
    logic [1:0]   low_index;
    logic [31:0]  dw0;
    logic [31:0]  dw1;
    logic [31:0]  dw2;
    logic [31:0]  dw3;
    logic         unused_cfg;

    assign accept    = (state == IDLE) && is_read_request;
    assign handshake = tx_valid && tx_ready;

`ifdef CPL_ADDR_CHECK_EN
    assign out_of_range = (read_addr >= ADDR_LIMIT);
    assign unused_cfg   = ^req_addr[1:0];
`else
    assign out_of_range = 1'b0;
    assign unused_cfg   = ^{req_addr[1:0], ADDR_LIMIT};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        pcie_read_ready = 1'b0;
        mem_rd_en       = 1'b0;
        tx_valid        = 1'b0;
        case (state)
            IDLE: begin
                pcie_read_ready = 1'b1;
                if (is_read_request) begin
                    state_next = out_of_range ? SEND : MEM_RD;
                end
            end
            MEM_RD: begin
                mem_rd_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_sop      = tx_valid;
    assign tx_eop      = tx_valid;
    assign mem_rd_addr = {req_addr[15:2], 2'b00};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_addr <= '0;
            req_be   <= '0;
            req_id   <= '0;
            req_tag  <= '0;
            req_ur   <= 1'b0;
        end else if (accept) begin
            req_addr <= read_addr;
            req_be   <= bit_enable;
            req_id   <= RequesterID;
            req_tag  <= tag;
            req_ur   <= out_of_range;
        end
    end

    // Counter reaches 1 in the cycle that is RD_LATENCY cycles after the strobe (legal range 1..15).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt <= '0;
            rd_word <= '0;
        end else begin
            if (state == MEM_RD) begin
                lat_cnt <= 4'(RD_LATENCY);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if ((state == WAIT) && (lat_cnt == 4'd1)) begin
                rd_word <= mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpl_count <= '0;
        end else if (handshake) begin
            cpl_count <= cpl_count + 16'd1;
        end
    end

    always_comb begin
        byte_count = 12'd1;
        casez (req_be)
            4'b1??1:                   byte_count = 12'd4;
            4'b01?1, 4'b1?10:          byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
            default:                   byte_count = 12'd1;
        endcase
    end

    always_comb begin
        low_index = 2'd0;
        casez (req_be)
            4'b???1: low_index = 2'd0;
            4'b??10: low_index = 2'd1;
            4'b?100: low_index = 2'd2;
            4'b1000: low_index = 2'd3;
            default: low_index = 2'd0;
        endcase
    end

    // Header is only driven while presenting, so the bus reads all-zero when idle.
    always_comb begin
        dw2 = {req_id, req_tag, 1'b0, req_addr[6:2], low_index};
        if (req_ur) begin
            dw0 = {3'b000, 5'b01010, 14'd0, 10'd0};
            dw1 = {COMPLETER_ID, 3'b001, 1'b0, 12'd0};
            dw3 = 32'd0;
        end else begin
            dw0 = {3'b010, 5'b01010, 14'd0, 10'd1};
            dw1 = {COMPLETER_ID, 3'b000, 1'b0, byte_count};
            dw3 = rd_word;
        end
        tx_data = '0;
        if (state == SEND) begin
            tx_data = {128'd0, dw3, dw2, dw1, dw0};
        end
    end

endmodule

// File: doc/pcie_cpl_gen.md
Name: pcie_cpl_gen

Overview:
- Downstream of the TLP packet decoder.
- Accepts one decoded memory-read request at a time, reads one 32-bit word from the local register/memory port, and builds a single-DW Completion-with-Data (CplD) TLP for the PCIe TX interface.
- Provides the `pcie_read_ready` back-pressure the decoder waits on.

Parameters:
- COMPLETER_ID, 16'h0100, bus/dev/func placed in the completion header.
- RD_LATENCY, 1, cycles from `mem_rd_en` to valid `mem_rd_data`; legal range 1..15.
- ADDR_LIMIT, 16'h1000, first byte address outside the local space. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- is_read_request  input  1  decoded read request valid
- pcie_read_ready  output  1  block can accept a request
- read_addr  input  16  request byte address
- bit_enable  input  4  first-DW byte enables
- RequesterID  input  16  requester ID from the request
- tag  input  8  request tag
- mem_rd_en  output  1  one-cycle read strobe
- mem_rd_addr  output  16  word-aligned read address
- mem_rd_data  input  32  read data
- tx_data  output  256  completion TLP
- tx_valid  output  1  TLP valid
- tx_sop  output  1  start of packet
- tx_eop  output  1  end of packet
- tx_ready  input  1  TX sink accepts
- cpl_count  output  16  completions sent, wrapping

Behaviour:
- **Reset values.** All outputs 0 except `pcie_read_ready`, which is 1. FSM in IDLE.
- **Async reset mid-operation.** Any pending request is dropped. `tx_valid` falls immediately.
- **FSM states: IDLE, MEM_RD, WAIT, SEND.**
- IDLE:
  - `pcie_read_ready` = 1 only in IDLE.
  - A request is accepted on a cycle where `is_read_request` && `pcie_read_ready`.
  - On acceptance, register `read_addr`, `bit_enable`, `RequesterID`, `tag` and go to MEM_RD.
- MEM_RD:
  - `mem_rd_en` = 1 for exactly one cycle.
  - `mem_rd_addr` = {addr[15:2], 2'b00}.
  - Load the latency counter with RD_LATENCY, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `mem_rd_data` and go to SEND.
  - The data is therefore sampled exactly RD_LATENCY cycles after the `mem_rd_en` cycle.
- SEND:
  - `tx_valid` = `tx_sop` = `tx_eop` = 1.
  - `tx_data` is held stable until `tx_ready`.
  - On `tx_valid` && `tx_ready`: `cpl_count` increments (wraps 16'hFFFF -> 0) and the FSM goes to IDLE.
  - A new request can be accepted in the cycle after the handshake.
- **Back-pressure.** `is_read_request` arriving while the block is not in IDLE is not consumed. The decoder holds it until `pcie_read_ready`.
- **Minimum latency.** Acceptance to `tx_valid` = RD_LATENCY + 2 cycles.
- **tx_data layout.** Bits [255:128] are 0.
  - DW0 [31:0]: Fmt 3'b010, Type 5'b01010, TC/Attr/TD/EP 0, Length 10'd1.
  - DW1 [63:32]: COMPLETER_ID[15:0], Status 3'b000, BCM 0, ByteCount[11:0].
  - DW2 [95:64]: RequesterID, tag, 1'b0, LowerAddr[6:0].
  - DW3 [127:96]: read data.
- **ByteCount.** Span from the lowest to the highest set bit of `bit_enable`:
  - 1xx1 -> 4
  - 01x1 and 1x10 -> 3
  - 0011, 0110, 1100 -> 2
  - single bit set -> 1
  - 0000 -> 1
- **LowerAddr.** {addr[6:2], lo}, where lo is the index of the lowest set enable bit; lo = 0 when `bit_enable` = 0000.

Optional Feature:
- Macro: CPL_ADDR_CHECK_EN.
- When defined, a request with `read_addr` >= ADDR_LIMIT:
  - skips MEM_RD and WAIT (no `mem_rd_en`);
  - goes straight to SEND with a Completion-without-data: Fmt 3'b000, Length 0, Status 3'b001 (UR), ByteCount 0, DW3 = 0;
  - still increments `cpl_count`.
- When undefined, all addresses are read from memory and no address comparator exists.

Test Plan:
- Reset-then-request, RD_LATENCY=1: addr 16'h0010, BE 4'hF, ReqID 16'h0200, tag 8'h05, mem returns 32'hDEADBEEF, `tx_ready`=1.
  - Expect `tx_valid` 3 cycles after acceptance.
  - Expect DW0 = 32'h4A000001, DW1 = 32'h01000004, DW2 = 32'h02000510, DW3 = 32'hDEADBEEF.
- BE decoding:
  - BE 4'b0100, addr 16'h0004 -> ByteCount 1, LowerAddr 7'h06.
  - BE 4'b0110 -> ByteCount 2.
  - BE 4'b0000 -> ByteCount 1, LowerAddr low bits 0.
- Back-pressure: hold `tx_ready`=0 for 5 cycles.
  - `tx_data` stays stable, `pcie_read_ready` stays 0.
  - A second held request is accepted only in the cycle after the handshake.
- RD_LATENCY=4: data sampled exactly 4 cycles after `mem_rd_en`. Bench drives wrong data on the other cycles; DW3 must carry the correct word.
- Reset asserted during WAIT and during SEND: `tx_valid` drops asynchronously, `pcie_read_ready` returns to 1, `cpl_count` is 0.
- CPL_ADDR_CHECK_EN defined: addr 16'h1000.
  - No `mem_rd_en`.
  - DW0 = 32'h0A000000, DW1 = 32'h01002000, `cpl_count` increments.
